// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding is built in only when HAZARD_FWD_EN is defined; see hazard_ctrl.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic             regwrite;
        logic             memread;
    } trackerEntry_t;

    // True when this in-flight entry will write register r; r0 never counts.
    function automatic logic writesReg(input trackerEntry_t e, input logic [REG_W-1:0] r);
        return e.valid && e.regwrite && (e.wreg != '0) && (e.wreg == r);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One slot of the EX/MEM/WB destination tracker: loads d, or a bubble, and
// clears synchronously while rst_n is low.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          bubble,
    input  trackerEntry_t d,
    output trackerEntry_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/RAW stall, branch flush and EX operand
// forwarding selects. Define HAZARD_FWD_EN to build the forwarding network.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [15:0]      stall_cnt
);

    trackerEntry_t idEntry;
    trackerEntry_t exEntry;
    trackerEntry_t memEntry;
    trackerEntry_t wbEntry;
    logic          exBubble;
    logic          rawHazard;
    logic          unusedTrackerBits;

    assign idEntry = '{valid: 1'b1, wreg: id_wreg, regwrite: id_regwrite, memread: id_memread};
    assign exBubble = flush_idex || !id_valid;

    hazard_stage_reg exStage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (exBubble),
        .d      (idEntry),
        .q      (exEntry)
    );

    hazard_stage_reg memStage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (exEntry),
        .q      (memEntry)
    );

    hazard_stage_reg wbStage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (memEntry),
        .q      (wbEntry)
    );

    // Not every tracker field feeds logic in both build variants.
    assign unusedTrackerBits = ^{exEntry, memEntry, wbEntry};

    always_comb begin
        rawHazard = 1'b0;
`ifdef HAZARD_FWD_EN
        // Only a load still in EX cannot be forwarded in time.
        rawHazard = id_valid && exEntry.valid && exEntry.memread && (exEntry.wreg != '0)
                    && ((exEntry.wreg == id_rs) || (id_uses_rt && (exEntry.wreg == id_rt)));
`else
        // Without forwarding, wait until no in-flight producer remains.
        rawHazard = id_valid
                    && (writesReg(exEntry, id_rs) || writesReg(memEntry, id_rs)
                        || writesReg(wbEntry, id_rs)
                        || (id_uses_rt && (writesReg(exEntry, id_rt) || writesReg(memEntry, id_rt)
                                           || writesReg(wbEntry, id_rt))));
`endif
        stall      = rawHazard && !br_taken;
        flush_idex = stall || br_taken;
        flush_ifid = br_taken;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

`ifdef HAZARD_FWD_EN
    logic       afterLoadStall;
    logic [1:0] fwdANext;
    logic [1:0] fwdBNext;

    // EX producer wins over MEM producer. A load that just forced a bubble is
    // delivered on the EX/MEM path to the consumer that waited for it.
    function automatic logic [1:0] pickSource(input trackerEntry_t ex, input trackerEntry_t mem,
                                              input logic [REG_W-1:0] r, input logic loadWait);
        if (writesReg(ex, r)) begin
            return FWD_MEM;
        end else if (writesReg(mem, r)) begin
            return loadWait ? FWD_MEM : FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwdANext = FWD_RF;
        fwdBNext = FWD_RF;
        if (id_valid && !flush_idex) begin
            fwdANext = pickSource(exEntry, memEntry, id_rs, afterLoadStall);
            if (id_uses_rt) begin
                fwdBNext = pickSource(exEntry, memEntry, id_rt, afterLoadStall);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a          <= FWD_RF;
            fwd_b          <= FWD_RF;
            afterLoadStall <= 1'b0;
        end else begin
            fwd_a          <= fwdANext;
            fwd_b          <= fwdBNext;
            afterLoadStall <= stall;
        end
    end
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; exercises the forwarding or
// the stall-only behaviour depending on whether HAZARD_FWD_EN is defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_wreg;
    logic        id_regwrite;
    logic        id_memread;
    logic        br_taken;
    logic        stall;
    logic        flush_ifid;
    logic        flush_idex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    int testsRun = 0;
    int failCount = 0;

    hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_wreg     (id_wreg),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .br_taken    (br_taken),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_uses_rt  = 1'b0;
        id_wreg     = '0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        br_taken    = 1'b0;
        #1;
    endtask

    task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                         input logic [4:0] wreg, input logic rw, input logic mr);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = usesRt;
        id_wreg     = wreg;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic drain();
        setIdle();
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0;
        setIdle();
        step();
        step();
        rst_n = 1'b1;
        #1;
        checkEq("reset_stall", {15'd0, stall}, 16'd0);
        checkEq("reset_flush_ifid", {15'd0, flush_ifid}, 16'd0);
        checkEq("reset_flush_idex", {15'd0, flush_idex}, 16'd0);
        checkEq("reset_fwd_a", {14'd0, fwd_a}, 16'd0);
        checkEq("reset_fwd_b", {14'd0, fwd_b}, 16'd0);
        checkEq("reset_stall_cnt", stall_cnt, 16'd0);

        // Branch with an empty tracker
        br_taken = 1'b1;
        #1;
        checkEq("br_empty_ifid", {15'd0, flush_ifid}, 16'd1);
        checkEq("br_empty_idex", {15'd0, flush_idex}, 16'd1);
        checkEq("br_empty_stall", {15'd0, stall}, 16'd0);
        step();
        setIdle();

`ifdef HAZARD_FWD_EN
        // add r3 then sub rs=r3: EX/MEM forward, no stall
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        checkEq("fw_ex_stall", {15'd0, stall}, 16'd0);
        step();
        checkEq("fw_ex_fwd_a", {14'd0, fwd_a}, 16'd1);
        checkEq("fw_ex_fwd_b", {14'd0, fwd_b}, 16'd0);
        drain();

        // r3 producer, independent op, consumer via rt: MEM/WB forward
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd7, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        setId(5'd10, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        step();
        checkEq("fw_mem_fwd_b", {14'd0, fwd_b}, 16'd2);
        checkEq("fw_mem_fwd_a", {14'd0, fwd_a}, 16'd0);
        drain();

        // lw r5 then add rs=r5: one-cycle load-use stall
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setId(5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        checkEq("lu_stall", {15'd0, stall}, 16'd1);
        checkEq("lu_flush_idex", {15'd0, flush_idex}, 16'd1);
        checkEq("lu_flush_ifid", {15'd0, flush_ifid}, 16'd0);
        step();
        checkEq("lu_stall_over", {15'd0, stall}, 16'd0);
        checkEq("lu_cnt", stall_cnt, 16'd1);
        checkEq("lu_bubble_fwd_a", {14'd0, fwd_a}, 16'd0);
        step();
        checkEq("lu_fwd_a", {14'd0, fwd_a}, 16'd1);
        checkEq("lu_fwd_b", {14'd0, fwd_b}, 16'd0);
        checkEq("lu_cnt_hold", stall_cnt, 16'd1);
        drain();

        // load-use coinciding with a taken branch
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setId(5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        br_taken = 1'b1;
        #1;
        checkEq("lubr_stall", {15'd0, stall}, 16'd0);
        checkEq("lubr_ifid", {15'd0, flush_ifid}, 16'd1);
        checkEq("lubr_idex", {15'd0, flush_idex}, 16'd1);
        step();
        setIdle();
        checkEq("lubr_cnt", stall_cnt, 16'd1);
        checkEq("lubr_fwd_a", {14'd0, fwd_a}, 16'd0);
        drain();

        // load in EX but ID empty
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setIdle();
        id_rs = 5'd5;
        #1;
        checkEq("lu_novalid_stall", {15'd0, stall}, 16'd0);
        drain();

        // r0 never forwards or stalls
        setId(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        setId(5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checkEq("r0_stall", {15'd0, stall}, 16'd0);
        step();
        checkEq("r0_fwd_a", {14'd0, fwd_a}, 16'd0);
        checkEq("r0_fwd_b", {14'd0, fwd_b}, 16'd0);
        drain();

        // Build stall_cnt up to 7, then reset mid-stall
        for (int i = 0; i < 6; i++) begin
            setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
            step();
            setId(5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
            step();
            step();
            drain();
        end
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setId(5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        checkEq("rst_pre_stall", {15'd0, stall}, 16'd1);
        checkEq("rst_pre_cnt", stall_cnt, 16'd7);
`else
        // add r3 then sub rs=r3: three stall cycles, no forwarding
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        checkEq("raw_stall_ex", {15'd0, stall}, 16'd1);
        checkEq("raw_flush_idex", {15'd0, flush_idex}, 16'd1);
        checkEq("raw_flush_ifid", {15'd0, flush_ifid}, 16'd0);
        step();
        checkEq("raw_stall_mem", {15'd0, stall}, 16'd1);
        checkEq("raw_cnt1", stall_cnt, 16'd1);
        checkEq("raw_fwd_a", {14'd0, fwd_a}, 16'd0);
        step();
        checkEq("raw_stall_wb", {15'd0, stall}, 16'd1);
        checkEq("raw_cnt2", stall_cnt, 16'd2);
        step();
        checkEq("raw_stall_done", {15'd0, stall}, 16'd0);
        checkEq("raw_idex_done", {15'd0, flush_idex}, 16'd0);
        checkEq("raw_cnt3", stall_cnt, 16'd3);
        step();
        checkEq("raw_fwd_a_after", {14'd0, fwd_a}, 16'd0);
        drain();

        // rt matches but is not a true source
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd4, 5'd3, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("nort_stall", {15'd0, stall}, 16'd0);
        step();
        drain();

        // lw r5 then consumer via rt
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setId(5'd6, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        checkEq("lu_rt_stall", {15'd0, stall}, 16'd1);
        checkEq("lu_rt_idex", {15'd0, flush_idex}, 16'd1);
        step();
        drain();
        checkEq("lu_rt_cnt", stall_cnt, 16'd4);

        // hazard coinciding with a taken branch
        setId(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        setId(5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        br_taken = 1'b1;
        #1;
        checkEq("lubr_stall", {15'd0, stall}, 16'd0);
        checkEq("lubr_ifid", {15'd0, flush_ifid}, 16'd1);
        checkEq("lubr_idex", {15'd0, flush_idex}, 16'd1);
        step();
        setIdle();
        checkEq("lubr_cnt", stall_cnt, 16'd4);
        drain();

        // r0 never stalls
        setId(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        setId(5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checkEq("r0_stall", {15'd0, stall}, 16'd0);
        step();
        checkEq("r0_fwd_a", {14'd0, fwd_a}, 16'd0);
        drain();

        // Two stalls, then ID empties while producer sits in WB
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        step();
        step();
        setIdle();
        id_rs = 5'd3;
        #1;
        checkEq("novalid_stall", {15'd0, stall}, 16'd0);
        drain();
        checkEq("mid_cnt", stall_cnt, 16'd6);

        // Reach stall_cnt=7 while still stalled, then reset
        setId(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        setId(5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        step();
        checkEq("rst_pre_stall", {15'd0, stall}, 16'd1);
        checkEq("rst_pre_cnt", stall_cnt, 16'd7);
`endif

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checkEq("rst_mid_stall", {15'd0, stall}, 16'd0);
        checkEq("rst_mid_cnt", stall_cnt, 16'd0);
        checkEq("rst_mid_fwd_a", {14'd0, fwd_a}, 16'd0);
        checkEq("rst_mid_fwd_b", {14'd0, fwd_b}, 16'd0);
        checkEq("rst_mid_idex", {15'd0, flush_idex}, 16'd0);
        step();
        checkEq("rst_after_fwd_a", {14'd0, fwd_a}, 16'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
